icache_refill_ctrl_module: RTL and testbench

//  Sequences instruction-fetch misses between the ITLB, the MMU page walker, the ICACHE arrays and memory.
//  One miss is outstanding at a time: ITLB miss -> walk -> ICACHE re-check -> line refill.

---
 rtl/icache_refill_ctrl_module.sv | 190 +++++++++++++++++++
 tb/tb_icache_refill_ctrl_module.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl_module.sv
// rtl/icache_refill_ctrl_module.sv - instruction-fetch miss sequencer between ITLB, MMU walker, ICACHE and memory
module icache_refill_ctrl_module #(
  parameter int VADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 34,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_req_vld,
  input  logic [VADDR_WIDTH-1:0] i_req_vaddr,
  input  logic                   i_itlb_hit,
  input  logic [21:0]            i_itlb_ppn,
  input  logic                   i_icache_hit,
  output logic                   o_itlb_mmu_vld,
  output logic [VADDR_WIDTH-1:0] o_itlb_mmu_vaddr,
  input  logic                   i_mmu_itlb_vld,
  input  logic [PADDR_WIDTH-1:0] i_mmu_itlb_paddr,
  input  logic [2:0]             i_mmu_itlb_excp,
  output logic                   o_itlb_wren,
  output logic                   o_icache_mem_vld,
  output logic [PADDR_WIDTH-1:0] o_icache_mem_paddr,
  input  logic                   i_mem_icache_vld,
  output logic                   o_icache_wren,
  output logic                   o_stall,
  output logic                   o_excp_vld,
  output logic [2:0]             o_excp_code,
  output logic [CNT_WIDTH-1:0]   o_itlb_miss_cnt,
  output logic [CNT_WIDTH-1:0]   o_icache_miss_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TLB_WAIT  = 3'd1,
    RECHK     = 3'd2,
    MEM_WAIT  = 3'd3,
    FILL      = 3'd4,
    DRAIN_TLB = 3'd5,
    DRAIN_MEM = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic                   mmu_vld_q, mmu_vld_d;
  logic [VADDR_WIDTH-1:0] mmu_vaddr_q, mmu_vaddr_d;
  logic                   itlb_wren_q, itlb_wren_d;
  logic                   mem_vld_q, mem_vld_d;
  logic [PADDR_WIDTH-1:0] mem_paddr_q, mem_paddr_d;
  logic                   icache_wren_q, icache_wren_d;
  logic                   excp_vld_q, excp_vld_d;
  logic [2:0]             excp_code_q, excp_code_d;
  logic [CNT_WIDTH-1:0]   itlb_cnt_q, itlb_cnt_d;
  logic [CNT_WIDTH-1:0]   icache_cnt_q, icache_cnt_d;

  // Page offset bits of the walk result are replaced by the fetch vaddr offset
  logic unused_paddr_lsb;
  assign unused_paddr_lsb = ^i_mmu_itlb_paddr[11:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Next-state and registered-output computation; pulses default low every cycle
  always_comb begin
    state_d       = state_q;
    mmu_vld_d     = 1'b0;
    mmu_vaddr_d   = mmu_vaddr_q;
    itlb_wren_d   = 1'b0;
    mem_vld_d     = 1'b0;
    mem_paddr_d   = mem_paddr_q;
    icache_wren_d = 1'b0;
    excp_vld_d    = 1'b0;
    excp_code_d   = 3'd0;
    itlb_cnt_d    = itlb_cnt_q;
    icache_cnt_d  = icache_cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req_vld && !i_flush) begin
          if (!i_itlb_hit) begin
            mmu_vaddr_d = i_req_vaddr;
            mmu_vld_d   = 1'b1;
            itlb_cnt_d  = sat_inc(itlb_cnt_q);
            state_d     = TLB_WAIT;
          end else if (!i_icache_hit) begin
            mem_paddr_d  = PADDR_WIDTH'({i_itlb_ppn, i_req_vaddr[11:6], 6'b0});
            mem_vld_d    = 1'b1;
            icache_cnt_d = sat_inc(icache_cnt_q);
            state_d      = MEM_WAIT;
          end
        end
      end
      TLB_WAIT: begin
        if (i_mmu_itlb_vld) begin
          if (i_flush) begin
            // Response coinciding with a flush is drained: fill the ITLB, report nothing
            itlb_wren_d = (i_mmu_itlb_excp == 3'd0);
            state_d     = IDLE;
          end else if (i_mmu_itlb_excp != 3'd0) begin
            excp_vld_d  = 1'b1;
            excp_code_d = i_mmu_itlb_excp;
            state_d     = IDLE;
          end else begin
            itlb_wren_d = 1'b1;
            mem_paddr_d = PADDR_WIDTH'({i_mmu_itlb_paddr[PADDR_WIDTH-1:12], mmu_vaddr_q[11:6], 6'b0});
            state_d     = RECHK;
          end
        end else if (i_flush) begin
          state_d = DRAIN_TLB;
        end
      end
      RECHK: begin
        if (i_flush || i_icache_hit) begin
          state_d = IDLE;
        end else begin
          mem_vld_d    = 1'b1;
          icache_cnt_d = sat_inc(icache_cnt_q);
          state_d      = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (i_mem_icache_vld) begin
          icache_wren_d = 1'b1;
          state_d       = FILL;
        end else if (i_flush) begin
          state_d = DRAIN_MEM;
        end
      end
      FILL: state_d = IDLE;
      DRAIN_TLB: begin
        if (i_mmu_itlb_vld) begin
          itlb_wren_d = (i_mmu_itlb_excp == 3'd0);
          state_d     = IDLE;
        end
      end
      DRAIN_MEM: begin
        if (i_mem_icache_vld) begin
          icache_wren_d = 1'b1;
          state_d       = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and drops late responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mmu_vld_q     <= 1'b0;
      mmu_vaddr_q   <= '0;
      itlb_wren_q   <= 1'b0;
      mem_vld_q     <= 1'b0;
      mem_paddr_q   <= '0;
      icache_wren_q <= 1'b0;
      excp_vld_q    <= 1'b0;
      excp_code_q   <= 3'd0;
      itlb_cnt_q    <= '0;
      icache_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      mmu_vld_q     <= mmu_vld_d;
      mmu_vaddr_q   <= mmu_vaddr_d;
      itlb_wren_q   <= itlb_wren_d;
      mem_vld_q     <= mem_vld_d;
      mem_paddr_q   <= mem_paddr_d;
      icache_wren_q <= icache_wren_d;
      excp_vld_q    <= excp_vld_d;
      excp_code_q   <= excp_code_d;
      itlb_cnt_q    <= itlb_cnt_d;
      icache_cnt_q  <= icache_cnt_d;
    end
  end

  // Stall is combinational so the IFU holds in the same cycle a miss is seen
  always_comb begin
    o_stall = (state_q == DRAIN_TLB) || (state_q == DRAIN_MEM) ||
              (i_req_vld && ((state_q != IDLE) || !i_itlb_hit || !i_icache_hit));
  end

  assign o_itlb_mmu_vld     = mmu_vld_q;
  assign o_itlb_mmu_vaddr   = mmu_vaddr_q;
  assign o_itlb_wren        = itlb_wren_q;
  assign o_icache_mem_vld   = mem_vld_q;
  assign o_icache_mem_paddr = mem_paddr_q;
  assign o_icache_wren      = icache_wren_q;
  assign o_excp_vld         = excp_vld_q;
  assign o_excp_code        = excp_code_q;
  assign o_itlb_miss_cnt    = itlb_cnt_q;
  assign o_icache_miss_cnt  = icache_cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl_module.sv
// tb/tb_icache_refill_ctrl_module.sv - vector table and scoreboard bench for icache_refill_ctrl_module
module tb_icache_refill_ctrl_module;

  logic        clk = 1'b0;
  logic        rst, flush, req_vld, itlb_hit, icache_hit, mmu_vld_in, mem_vld_in;
  logic [31:0] req_vaddr;
  logic [21:0] itlb_ppn;
  logic [33:0] mmu_paddr;
  logic [2:0]  mmu_excp;

  logic        mmu_vld_o, itlb_wren, mem_vld_o, icache_wren, stall, excp_vld;
  logic [31:0] mmu_vaddr_o;
  logic [33:0] mem_paddr_o;
  logic [2:0]  excp_code;
  logic [15:0] tcnt, ccnt;

  logic        s_mmu_vld_o, s_itlb_wren, s_mem_vld_o, s_icache_wren, s_stall, s_excp_vld;
  logic [31:0] s_mmu_vaddr_o;
  logic [33:0] s_mem_paddr_o;
  logic [2:0]  s_excp_code;
  logic [1:0]  s_tcnt, s_ccnt;

  always #5 clk = ~clk;

  icache_refill_ctrl_module dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_req_vld(req_vld), .i_req_vaddr(req_vaddr),
    .i_itlb_hit(itlb_hit), .i_itlb_ppn(itlb_ppn), .i_icache_hit(icache_hit),
    .o_itlb_mmu_vld(mmu_vld_o), .o_itlb_mmu_vaddr(mmu_vaddr_o),
    .i_mmu_itlb_vld(mmu_vld_in), .i_mmu_itlb_paddr(mmu_paddr), .i_mmu_itlb_excp(mmu_excp),
    .o_itlb_wren(itlb_wren), .o_icache_mem_vld(mem_vld_o), .o_icache_mem_paddr(mem_paddr_o),
    .i_mem_icache_vld(mem_vld_in), .o_icache_wren(icache_wren), .o_stall(stall),
    .o_excp_vld(excp_vld), .o_excp_code(excp_code),
    .o_itlb_miss_cnt(tcnt), .o_icache_miss_cnt(ccnt)
  );

  // Narrow-counter copy sharing the same stimulus, used to observe saturation
  icache_refill_ctrl_module #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .i_flush(flush), .i_req_vld(req_vld), .i_req_vaddr(req_vaddr),
    .i_itlb_hit(itlb_hit), .i_itlb_ppn(itlb_ppn), .i_icache_hit(icache_hit),
    .o_itlb_mmu_vld(s_mmu_vld_o), .o_itlb_mmu_vaddr(s_mmu_vaddr_o),
    .i_mmu_itlb_vld(mmu_vld_in), .i_mmu_itlb_paddr(mmu_paddr), .i_mmu_itlb_excp(mmu_excp),
    .o_itlb_wren(s_itlb_wren), .o_icache_mem_vld(s_mem_vld_o), .o_icache_mem_paddr(s_mem_paddr_o),
    .i_mem_icache_vld(mem_vld_in), .o_icache_wren(s_icache_wren), .o_stall(s_stall),
    .o_excp_vld(s_excp_vld), .o_excp_code(s_excp_code),
    .o_itlb_miss_cnt(s_tcnt), .o_icache_miss_cnt(s_ccnt)
  );

  typedef struct {
    string       name;
    logic        rst, fl, rq, ith, ich, mv, memv;
    logic [31:0] va;
    logic [21:0] ppn;
    logic [33:0] mpa;
    logic [2:0]  ex;
    logic        e_st;
    logic [4:0]  e_pl;
    logic [2:0]  e_code;
    logic [15:0] e_tc, e_cc;
    logic [33:0] e_mp;
    logic [31:0] e_mv;
  } vec_t;

  vec_t tab[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(string nm, logic r, logic f, logic q, logic [31:0] va, logic ith,
                              logic [21:0] ppn, logic ich, logic mv, logic [33:0] mpa, logic [2:0] ex,
                              logic memv, logic st, logic [4:0] pl, logic [2:0] code,
                              logic [15:0] tc, logic [15:0] cc, logic [33:0] mp, logic [31:0] mva);
    vec_t v;
    v.name = nm; v.rst = r; v.fl = f; v.rq = q; v.va = va; v.ith = ith; v.ppn = ppn; v.ich = ich;
    v.mv = mv; v.mpa = mpa; v.ex = ex; v.memv = memv; v.e_st = st; v.e_pl = pl; v.e_code = code;
    v.e_tc = tc; v.e_cc = cc; v.e_mp = mp; v.e_mv = mva;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; req_vld = 1'b0; req_vaddr = '0; itlb_hit = 1'b0; itlb_ppn = '0;
    icache_hit = 1'b0; mmu_vld_in = 1'b0; mmu_paddr = '0; mmu_excp = '0; mem_vld_in = 1'b0;
  endtask

  // sel: 0 mmu request, 1 itlb write, 2 mem request, 3 icache write
  task automatic wait_pulse(input string nm, input int sel, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      case (sel)
        0: seen = (mmu_vld_o === 1'b1);
        1: seen = (itlb_wren === 1'b1);
        2: seen = (mem_vld_o === 1'b1);
        default: seen = (icache_wren === 1'b1);
      endcase
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: pulse got 0 expected 1 within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    vec_t e;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //            name           rst f q vaddr         ith ppn       ich mv mpaddr          ex memv  st pulses   code tc cc mem_paddr       mmu_vaddr
    tab.push_back(mk("rst",        1,0,0,32'h0,        0,22'h0,     0,0,34'h0,          0, 0,    0,5'b00000,0, 0,0,34'h0,          32'h0));
    tab.push_back(mk("hit",        0,0,1,32'h1000,     1,22'h0,     1,0,34'h0,          0, 0,    0,5'b00000,0, 0,0,34'h0,          32'h0));
    tab.push_back(mk("miss_acc",   0,0,1,32'h80001234, 0,22'h0,     0,0,34'h0,          0, 0,    1,5'b10000,0, 1,0,34'h0,          32'h80001234));
    tab.push_back(mk("tlb_wait",   0,0,1,32'h80001234, 0,22'h0,     0,0,34'h0,          0, 0,    1,5'b00000,0, 1,0,34'h0,          32'h80001234));
    tab.push_back(mk("walk_rsp",   0,0,1,32'h80001234, 0,22'h0,     0,1,34'h240000000,  0, 0,    1,5'b01000,0, 1,0,34'h240000200,  32'h80001234));
    tab.push_back(mk("rechk_miss", 0,0,1,32'h80001234, 1,22'h0,     0,0,34'h0,          0, 0,    1,5'b00100,0, 1,1,34'h240000200,  32'h80001234));
    tab.push_back(mk("mem_wait",   0,0,1,32'h80001234, 1,22'h0,     0,0,34'h0,          0, 0,    1,5'b00000,0, 1,1,34'h240000200,  32'h80001234));
    tab.push_back(mk("mem_rsp",    0,0,1,32'h80001234, 1,22'h0,     0,0,34'h0,          0, 1,    1,5'b00010,0, 1,1,34'h240000200,  32'h80001234));
    tab.push_back(mk("fill",       0,0,1,32'h80001234, 1,22'h0,     1,0,34'h0,          0, 0,    1,5'b00000,0, 1,1,34'h240000200,  32'h80001234));
    tab.push_back(mk("hit2",       0,0,1,32'h80001234, 1,22'h0,     1,0,34'h0,          0, 0,    0,5'b00000,0, 1,1,34'h240000200,  32'h80001234));
    tab.push_back(mk("miss2",      0,0,1,32'h5000,     0,22'h0,     0,0,34'h0,          0, 0,    1,5'b10000,0, 2,1,34'h240000200,  32'h5000));
    tab.push_back(mk("fault",      0,0,1,32'h5000,     0,22'h0,     0,1,34'h3ffffffff,  5, 0,    1,5'b00001,5, 2,1,34'h240000200,  32'h5000));
    tab.push_back(mk("idle_f",     0,0,0,32'h0,        0,22'h0,     0,0,34'h0,          0, 0,    0,5'b00000,0, 2,1,34'h240000200,  32'h5000));
    tab.push_back(mk("miss3",      0,0,1,32'h3040,     1,22'h12345, 0,0,34'h0,          0, 0,    1,5'b00100,0, 2,2,34'h012345040,  32'h5000));
    tab.push_back(mk("flush_mw",   0,1,1,32'h3040,     1,22'h0,     1,0,34'h0,          0, 0,    1,5'b00000,0, 2,2,34'h012345040,  32'h5000));
    tab.push_back(mk("drain_m0",   0,0,1,32'h3040,     1,22'h0,     1,0,34'h0,          0, 0,    1,5'b00000,0, 2,2,34'h012345040,  32'h5000));
    tab.push_back(mk("drain_m1",   0,1,1,32'h3040,     1,22'h0,     1,0,34'h0,          0, 0,    1,5'b00000,0, 2,2,34'h012345040,  32'h5000));
    tab.push_back(mk("drain_m2",   0,0,0,32'h3040,     1,22'h0,     1,0,34'h0,          0, 0,    1,5'b00000,0, 2,2,34'h012345040,  32'h5000));
    tab.push_back(mk("drain_rsp",  0,0,1,32'h3040,     1,22'h0,     1,0,34'h0,          0, 1,    1,5'b00010,0, 2,2,34'h012345040,  32'h5000));
    tab.push_back(mk("fill2",      0,0,1,32'h3040,     1,22'h0,     1,0,34'h0,          0, 0,    1,5'b00000,0, 2,2,34'h012345040,  32'h5000));
    tab.push_back(mk("new_req",    0,0,1,32'h4000,     0,22'h0,     0,0,34'h0,          0, 0,    1,5'b10000,0, 3,2,34'h012345040,  32'h4000));
    tab.push_back(mk("flush_rsp",  0,1,1,32'h4000,     0,22'h0,     0,1,34'h240000000,  2, 0,    1,5'b00000,0, 3,2,34'h012345040,  32'h4000));
    tab.push_back(mk("idle_chk",   0,0,1,32'h4000,     1,22'h0,     1,0,34'h0,          0, 0,    0,5'b00000,0, 3,2,34'h012345040,  32'h4000));
    tab.push_back(mk("miss5",      0,0,1,32'h7000,     0,22'h0,     0,0,34'h0,          0, 0,    1,5'b10000,0, 4,2,34'h012345040,  32'h7000));
    tab.push_back(mk("rsp5",       0,0,1,32'h7000,     0,22'h0,     0,1,34'h100000000,  0, 0,    1,5'b01000,0, 4,2,34'h100000000,  32'h7000));
    tab.push_back(mk("flush_rechk",0,1,1,32'h7000,     1,22'h0,     0,0,34'h0,          0, 0,    1,5'b00000,0, 4,2,34'h100000000,  32'h7000));
    tab.push_back(mk("idle_chk2",  0,0,0,32'h0,        0,22'h0,     0,0,34'h0,          0, 0,    0,5'b00000,0, 4,2,34'h100000000,  32'h7000));
    tab.push_back(mk("miss6",      0,0,1,32'h9000,     0,22'h0,     0,0,34'h0,          0, 0,    1,5'b10000,0, 5,2,34'h100000000,  32'h9000));
    tab.push_back(mk("flush_tw",   0,1,1,32'h9000,     0,22'h0,     0,0,34'h0,          0, 0,    1,5'b00000,0, 5,2,34'h100000000,  32'h9000));
    tab.push_back(mk("drain_t_rsp",0,0,1,32'h9000,     0,22'h0,     0,1,34'h300000000,  0, 0,    1,5'b01000,0, 5,2,34'h100000000,  32'h9000));
    tab.push_back(mk("idle3",      0,0,0,32'h0,        0,22'h0,     0,0,34'h0,          0, 0,    0,5'b00000,0, 5,2,34'h100000000,  32'h9000));
    tab.push_back(mk("miss7",      0,0,1,32'hA080,     1,22'h3,     0,0,34'h0,          0, 0,    1,5'b00100,0, 5,3,34'h3080,       32'h9000));
    tab.push_back(mk("rst_mw",     1,0,0,32'h0,        0,22'h0,     0,0,34'h0,          0, 0,    0,5'b00000,0, 0,0,34'h0,          32'h0));
    tab.push_back(mk("late_rsp",   0,0,0,32'h0,        0,22'h0,     0,0,34'h0,          0, 1,    0,5'b00000,0, 0,0,34'h0,          32'h0));
    tab.push_back(mk("idle_rsp",   0,0,0,32'h0,        0,22'h0,     0,1,34'h240000000,  3, 0,    0,5'b00000,0, 0,0,34'h0,          32'h0));

    foreach (tab[i]) begin
      @(negedge clk);
      rst = tab[i].rst; flush = tab[i].fl; req_vld = tab[i].rq; req_vaddr = tab[i].va;
      itlb_hit = tab[i].ith; itlb_ppn = tab[i].ppn; icache_hit = tab[i].ich;
      mmu_vld_in = tab[i].mv; mmu_paddr = tab[i].mpa; mmu_excp = tab[i].ex; mem_vld_in = tab[i].memv;
      sb.push_back(tab[i]);
      #1;
      if (!tab[i].rst) chk({tab[i].name, ".stall"}, 64'(stall), 64'(tab[i].e_st));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      chk({e.name, ".pulses"}, 64'({mmu_vld_o, itlb_wren, mem_vld_o, icache_wren, excp_vld}), 64'(e.e_pl));
      chk({e.name, ".excp_code"}, 64'(excp_code), 64'(e.e_code));
      chk({e.name, ".itlb_cnt"}, 64'(tcnt), 64'(e.e_tc));
      chk({e.name, ".icache_cnt"}, 64'(ccnt), 64'(e.e_cc));
      chk({e.name, ".mem_paddr"}, 64'(mem_paddr_o), 64'(e.e_mp));
      chk({e.name, ".mmu_vaddr"}, 64'(mmu_vaddr_o), 64'(e.e_mv));
      chk({e.name, ".itlb_cnt_sat"}, 64'(s_tcnt), (e.e_tc > 16'd3) ? 64'd3 : 64'(e.e_tc));
      chk({e.name, ".icache_cnt_sat"}, 64'(s_ccnt), (e.e_cc > 16'd3) ? 64'd3 : 64'(e.e_cc));
    end

    // Full miss with delayed walk and memory responses, waits bounded
    @(negedge clk);
    idle_inputs();
    req_vld = 1'b1; req_vaddr = 32'h0000_B0C0;
    wait_pulse("seq.mmu_req", 0, 4);
    chk("seq.mmu_vaddr", 64'(mmu_vaddr_o), 64'h0000_B0C0);
    repeat (3) @(negedge clk);
    mmu_vld_in = 1'b1; mmu_paddr = 34'h0_5555_5000; mmu_excp = 3'd0;
    wait_pulse("seq.itlb_wren", 1, 3);
    @(negedge clk);
    mmu_vld_in = 1'b0; itlb_hit = 1'b1; icache_hit = 1'b0;
    wait_pulse("seq.mem_req", 2, 3);
    chk("seq.mem_paddr", 64'(mem_paddr_o), 64'h0_5555_50C0);
    repeat (2) @(negedge clk);
    mem_vld_in = 1'b1;
    wait_pulse("seq.icache_wren", 3, 3);
    @(negedge clk);
    mem_vld_in = 1'b0; icache_hit = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    chk("seq.itlb_cnt", 64'(tcnt), 64'd1);
    chk("seq.icache_cnt", 64'(ccnt), 64'd1);
    chk("seq.idle_stall", 64'(stall), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
